// File: rtl/gear_mode_ctrl.sv
// Gear selector for the mode digit: turns P/R/D button edges into legal gear
// changes under ignition, brake and stopped interlocks, with error hold and lockout.
module gear_mode_ctrl #(
  parameter int LOCKOUT_CYCLES = 8,
  parameter int ERR_CYCLES     = 16,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ign_on,
  input  logic       brake,
  input  logic       stopped,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] mode,
  output logic       leading_zero,
  output logic       shift_ok,
  output logic       shift_err
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_PARK  = 2'd1,
    ST_REV   = 2'd2,
    ST_DRIVE = 2'd3
  } gear_state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES);
  localparam logic [CNT_W-1:0] ERR_LOAD  = CNT_W'(ERR_CYCLES);

  gear_state_t      state_reg, state_next;
  logic             btn_up_q, btn_down_q;
  logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic             leading_zero_reg;
  logic             shift_ok_reg, shift_ok_next;
  logic             shift_err_reg;

  logic up_e, down_e;
  logic up_legal, down_legal;

  assign up_e   = btn_up & ~btn_up_q;
  assign down_e = btn_down & ~btn_down_q;

  // Interlocks that make each direction legal from the current gear.
  always_comb begin
    up_legal   = 1'b0;
    down_legal = 1'b0;
    case (state_reg)
      ST_PARK:  up_legal = brake;
      ST_REV: begin
        up_legal   = stopped;
        down_legal = stopped & brake;
      end
      ST_DRIVE: down_legal = stopped;
      default: begin
        up_legal   = 1'b0;
        down_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    shift_ok_next = 1'b0;
    lock_cnt_next = (lock_cnt_reg != CNT_ZERO) ? lock_cnt_reg - CNT_ONE : CNT_ZERO;
    err_cnt_next  = (err_cnt_reg != CNT_ZERO) ? err_cnt_reg - CNT_ONE : CNT_ZERO;

    if (!ign_on && stopped) begin
      state_next = ST_OFF;
    end else if (state_reg == ST_OFF) begin
      if (ign_on && brake) state_next = ST_PARK;
    end else if (up_e && down_e) begin
      err_cnt_next = ERR_LOAD;
    end else if (lock_cnt_reg != CNT_ZERO) begin
      state_next = state_reg;
    end else if (up_e) begin
      if (up_legal) begin
        state_next    = gear_state_t'(state_reg + 2'd1);
        shift_ok_next = 1'b1;
        lock_cnt_next = LOCK_LOAD;
        err_cnt_next  = CNT_ZERO;
      end else begin
        err_cnt_next = ERR_LOAD;
      end
    end else if (down_e) begin
      if (down_legal) begin
        state_next    = gear_state_t'(state_reg - 2'd1);
        shift_ok_next = 1'b1;
        lock_cnt_next = LOCK_LOAD;
        err_cnt_next  = CNT_ZERO;
      end else begin
        err_cnt_next = ERR_LOAD;
      end
    end
  end

  // Buttons held through reset must not look like fresh presses, so the
  // edge history resets high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_OFF;
      btn_up_q         <= 1'b1;
      btn_down_q       <= 1'b1;
      lock_cnt_reg     <= CNT_ZERO;
      err_cnt_reg      <= CNT_ZERO;
      leading_zero_reg <= 1'b1;
      shift_ok_reg     <= 1'b0;
      shift_err_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      btn_up_q         <= btn_up;
      btn_down_q       <= btn_down;
      lock_cnt_reg     <= lock_cnt_next;
      err_cnt_reg      <= err_cnt_next;
      leading_zero_reg <= (state_next == ST_OFF);
      shift_ok_reg     <= shift_ok_next;
      shift_err_reg    <= (err_cnt_next != CNT_ZERO);
    end
  end

  assign mode         = state_reg;
  assign leading_zero = leading_zero_reg;
  assign shift_ok     = shift_ok_reg;
  assign shift_err    = shift_err_reg;

endmodule

// File: tb/tb_gear_mode_ctrl.sv
// Scoreboard bench for gear_mode_ctrl: a driver pushes reference-model
// expectations per cycle, a monitor pops and compares after each rising edge.
module tb_gear_mode_ctrl;

  localparam int LOCK = 8;
  localparam int ERRC = 16;

  logic       clk = 1'b0;
  logic       reset, ign_on, brake, stopped, btn_up, btn_down;
  logic [1:0] mode;
  logic       leading_zero, shift_ok, shift_err;

  gear_mode_ctrl #(.LOCKOUT_CYCLES(LOCK), .ERR_CYCLES(ERRC), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .ign_on(ign_on), .brake(brake), .stopped(stopped),
    .btn_up(btn_up), .btn_down(btn_down), .mode(mode),
    .leading_zero(leading_zero), .shift_ok(shift_ok), .shift_err(shift_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic       lz;
    logic       ok;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;

  // Reference model state: gear as a number 0..3 and remaining cycle counts.
  int gear = 0, lock_left = 0, err_left = 0;
  bit prev_up = 1, prev_dn = 1;

  bit r, i, b, s, u, d;

  task automatic model_step();
    bit ue, de, legal, ok;
    int nl, ne;
    exp_t e;
    ok = 0;
    if (r) begin
      gear = 0; lock_left = 0; err_left = 0; prev_up = 1; prev_dn = 1;
    end else begin
      ue = u && !prev_up;
      de = d && !prev_dn;
      prev_up = u;
      prev_dn = d;
      nl = (lock_left > 0) ? lock_left - 1 : 0;
      ne = (err_left > 0) ? err_left - 1 : 0;
      if (!i && s) gear = 0;
      else if (gear == 0) begin
        if (i && b) gear = 1;
      end else if (ue && de) ne = ERRC;
      else if (lock_left > 0) begin
      end else if (ue || de) begin
        if (ue) legal = (gear == 1 && b) || (gear == 2 && s);
        else    legal = (gear == 2 && s && b) || (gear == 3 && s);
        if (legal) begin
          gear = ue ? gear + 1 : gear - 1;
          ok = 1; nl = LOCK; ne = 0;
        end else ne = ERRC;
      end
      lock_left = nl;
      err_left  = ne;
    end
    e.mode = 2'(gear);
    e.lz   = (gear == 0);
    e.ok   = ok;
    e.err  = (err_left != 0);
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset = r; ign_on = i; brake = b; stopped = s; btn_up = u; btn_down = d;
      model_step();
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cycle, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mode", int'(mode), int'(e.mode));
        check("leading_zero", int'(leading_zero), int'(e.lz));
        check("shift_ok", int'(shift_ok), int'(e.ok));
        check("shift_err", int'(shift_err), int'(e.err));
        $display("cyc=%0d mode=%0d lz=%0b ok=%0b err=%0b", cycle, mode, leading_zero, shift_ok, shift_err);
      end
    end
  end

  initial begin : driver
    r = 1; i = 0; b = 0; s = 1; u = 1; d = 0;
    tick(3);
    r = 0; tick(3);
    i = 1; b = 1; tick(1);
    u = 0; tick(1);
    u = 1; tick(1);
    u = 0; tick(2);
    u = 1; tick(1);
    u = 0; tick(10);
    u = 1; tick(1);
    u = 0; tick(10);
    u = 1; tick(1);
    u = 0; tick(20);
    s = 0; d = 1; tick(1);
    d = 0; tick(9);
    d = 1; tick(1);
    d = 0; tick(20);
    s = 1; d = 1; tick(1);
    d = 0; tick(10);
    u = 1; d = 1; tick(1);
    u = 0; d = 0; tick(3);
    d = 1; tick(1);
    d = 0; tick(3);
    i = 0; tick(2);
    i = 1; b = 0; tick(4);
    b = 1; tick(2);
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 299) == 0);
      i = ($urandom_range(0, 15) != 0);
      b = ($urandom_range(0, 1) == 1);
      s = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) u = ~u;
      if ($urandom_range(0, 3) == 0) d = ~d;
      tick(1);
    end
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gear_mode_ctrl.md
Name: gear_mode_ctrl

Overview:
- Gear-selector controller that produces the 2-bit mode code and the leading_zero flag for the mode seven-segment digit.
- Mode codes: 0 = OFF, 1 = P, 2 = R, 3 = D.
- Tracks ignition, brake and vehicle-stopped interlocks, and converts shift-button presses into legal P/R/D transitions.
- Rejects illegal shifts, then applies an error-hold window and a post-shift lockout.

Parameters:
- LOCKOUT_CYCLES, default 8, cycles after an accepted shift during which further shift edges are ignored (no error flagged).
- ERR_CYCLES, default 16, cycles shift_err stays high after a rejected shift.
- CNT_W, default 8, width of the lockout and error counters; must hold max(LOCKOUT_CYCLES, ERR_CYCLES).

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- ign_on, input, 1, ignition level.
- brake, input, 1, brake pedal level.
- stopped, input, 1, vehicle speed is zero.
- btn_up, input, 1, shift toward D (P→R→D), level, already synchronised/debounced.
- btn_down, input, 1, shift toward P (D→R→P), level, already synchronised/debounced.
- mode, output, 2, gear code to the display digit (0 OFF, 1 P, 2 R, 3 D).
- leading_zero, output, 1, 1 when mode = OFF so the digit shows blank.
- shift_ok, output, 1, one-cycle pulse on the cycle after an accepted shift edge.
- shift_err, output, 1, high for ERR_CYCLES after a rejected shift.

Behaviour:
- Registered outputs; reset values: mode = 0, leading_zero = 1, shift_ok = 0, shift_err = 0.
- Reset also clears both counters and sets btn_up_q = btn_down_q = 1, so a button held through reset does not produce an edge.
- Edge detect: up_e = btn_up & ~btn_up_q (same for down_e). The _q registers update every cycle.
- Latency: the state and mode update on the same clock edge at which the button is first sampled high (1 cycle, input to output).
- States OFF/PARK/REV/DRIVE map directly onto mode codes 0/1/2/3.
- Transition priority per cycle, highest first: reset > ignition > simultaneous-edge rejection > lockout > shift.
- Ignition rules:
  - OFF → PARK when ign_on & brake. No shift_ok or lockout is generated; shift edges are ignored in OFF.
  - Any state → OFF when ign_on = 0 and stopped = 1. This forced change does not pulse shift_ok or load the lockout.
  - ign_on = 0 with stopped = 0: state holds and shift edges are still processed normally.
- Simultaneous up_e and down_e: no state change; counted as a reject.
- Lockout counter nonzero: all edges are ignored silently (no state change, no shift_ok, no error); the counter decrements each cycle.
- Accepted shifts:
  - PARK →(up_e & brake)→ REV.
  - REV →(up_e & stopped)→ DRIVE.
  - REV →(down_e & stopped & brake)→ PARK.
  - DRIVE →(down_e & stopped)→ REV.
- Rejected shifts: any other up_e or down_e outside OFF, e.g. up_e in DRIVE, down_e in PARK, or a missing interlock.
- On accept:
  - shift_ok = 1 for exactly one cycle.
  - Lockout counter loads LOCKOUT_CYCLES; edges are ignored for that many subsequent cycles.
  - Error counter clears and shift_err drops.
- On reject:
  - State unchanged.
  - Error counter loads ERR_CYCLES; shift_err is high while the counter is nonzero.
  - A new reject while shift_err is high reloads the counter (extends the window).
- Counters saturate at 0; no wrap-around.
- A reset mid-window clears everything in the same edge.
- leading_zero = (next state == OFF), registered together with mode so the two never disagree.

Test Plan:
- Reset held 3 cycles with btn_up = 1 → mode = 0, leading_zero = 1, all flags 0. After release, no edge is produced while btn_up stays high.
- ign_on = 1, brake = 1 → mode = 1 next edge, leading_zero = 0. Then up_e with brake = 1 → mode = 2, shift_ok pulses 1 cycle. Second up_e 3 cycles later → ignored by lockout, mode stays 2, shift_err = 0.
- From REV with stopped = 1, after lockout expires: up_e → mode = 3. Then up_e again in DRIVE → mode stays 3, shift_err high exactly 16 cycles.
- DRIVE with stopped = 0: down_e → rejected, mode = 3. Second reject at cycle 10 of the window → shift_err stays high 16 cycles from the second reject.
- btn_up and btn_down rise on the same cycle in REV → mode = 2, shift_err = 1, shift_ok = 0.
- In PARK, ign_on → 0 with stopped = 1 → mode = 0, leading_zero = 1, shift_ok = 0. Then ign_on = 1 with brake = 0 → stays 0 until brake = 1.
